// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - execute-stage sequencer: register file, ALU operand issue, fixed-latency writeback
module alu_issue_wb #(
  parameter int EXEC_WAIT = 1,
  parameter int NREG      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [7:0] issue_inst,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] alu_ra,
  output logic [7:0] alu_rb,
  output logic [7:0] alu_inst,
  input  logic [7:0] alu_rd,
  input  logic [7:0] alu_flags,
  output logic       wb_done,
  output logic [7:0] flags_q,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] regs [NREG];

  // Only these opcodes produce a result worth keeping; everything else just completes.
  function automatic logic writes_back(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b0101: writes_back = 1'b1;
      default:                                             writes_back = 1'b0;
    endcase
  endfunction

  // Sequencer: owns the FSM, register file, operand latches and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_ra      <= '0;
      alu_rb      <= '0;
      alu_inst    <= '0;
      flags_q     <= '0;
      wb_done     <= 1'b0;
      issue_ready <= 1'b1;
      ld_ready    <= 1'b1;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are read from the pre-load contents; a same-edge load still lands.
          if (ld_valid) regs[ld_addr] <= ld_data;
          if (issue_valid) begin
            alu_ra      <= regs[issue_inst[3:2]];
            alu_rb      <= regs[issue_inst[1:0]];
            alu_inst    <= issue_inst;
            cnt         <= 4'(EXEC_WAIT - 1);
            issue_ready <= 1'b0;
            ld_ready    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            wb_done <= 1'b1;
            state   <= WB;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB: begin
          if (writes_back(alu_inst[7:4])) begin
            regs[alu_inst[3:2]] <= alu_rd;
            flags_q             <= alu_flags;
          end
          alu_inst    <= '0;
          wb_done     <= 1'b0;
          issue_ready <= 1'b1;
          ld_ready    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - randomized self-checking bench for alu_issue_wb (EXEC_WAIT=1 and 3 instances)
module tb_alu_issue_wb;

  logic       clk;
  logic       rst_n;
  logic       issue_valid [2];
  logic       issue_ready [2];
  logic [7:0] issue_inst  [2];
  logic       ld_valid    [2];
  logic       ld_ready    [2];
  logic [1:0] ld_addr     [2];
  logic [7:0] ld_data     [2];
  logic [7:0] alu_ra      [2];
  logic [7:0] alu_rb      [2];
  logic [7:0] alu_inst    [2];
  logic [7:0] alu_rd      [2];
  logic [7:0] alu_flags   [2];
  logic       wb_done     [2];
  logic [7:0] flags_q     [2];
  logic [1:0] rd_addr     [2];
  logic [7:0] rd_data     [2];

  int total = 0;
  int bad   = 0;

  // Reference architectural state per instance
  logic [7:0] mr     [2][4];
  logic [7:0] mflags [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] inst);
    logic [15:0] p;
    case (inst[7:4])
      4'hA: return a + b;
      4'hB: return a - b;
      4'h8: return a + 8'd1;
      4'h9: return a - 8'd1;
      4'h4: begin p = a * b; return p[7:0]; end
      4'h5: begin p = 16'($signed(a) * $signed(b)); return p[7:0]; end
      default: return a ^ b ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] flag_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] inst);
    logic [7:0] r;
    r = alu_fn(a, b, inst);
    return {inst[7:4], r[7:4]} ^ {a[3:0], b[3:0]} ^ {7'd0, r == 8'd0};
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5};
  endfunction

  function automatic int ew(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign alu_rd[g]    = alu_fn(alu_ra[g], alu_rb[g], alu_inst[g]);
    assign alu_flags[g] = flag_fn(alu_ra[g], alu_rb[g], alu_inst[g]);
  end

  alu_issue_wb #(.EXEC_WAIT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid[0]), .issue_ready(issue_ready[0]), .issue_inst(issue_inst[0]),
    .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
    .alu_ra(alu_ra[0]), .alu_rb(alu_rb[0]), .alu_inst(alu_inst[0]),
    .alu_rd(alu_rd[0]), .alu_flags(alu_flags[0]),
    .wb_done(wb_done[0]), .flags_q(flags_q[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0])
  );

  alu_issue_wb #(.EXEC_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid[1]), .issue_ready(issue_ready[1]), .issue_inst(issue_inst[1]),
    .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
    .alu_ra(alu_ra[1]), .alu_rb(alu_rb[1]), .alu_inst(alu_inst[1]),
    .alu_rd(alu_rd[1]), .alu_flags(alu_flags[1]),
    .wb_done(wb_done[1]), .flags_q(flags_q[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1])
  );

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      mflags[d] = 8'h00;
      for (int i = 0; i < 4; i++) mr[d][i] = 8'h00;
    end
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr[d] = 2'(i);
      #1;
      total++;
      if (rd_data[d] !== mr[d][i]) begin
        bad++;
        $display("FAIL %s d=%0d R%0d got=%h exp=%h", tag, d, i, rd_data[d], mr[d][i]);
      end
    end
    total++;
    if (flags_q[d] !== mflags[d]) begin
      bad++;
      $display("FAIL %s d=%0d flags_q got=%h exp=%h", tag, d, flags_q[d], mflags[d]);
    end
  endtask

  task automatic do_load(input int d, input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    total++;
    if (ld_ready[d] !== 1'b1) begin
      bad++;
      $display("FAIL ld_ready_idle d=%0d got=%b exp=1", d, ld_ready[d]);
    end
    ld_valid[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
    @(negedge clk);
    ld_valid[d] = 1'b0;
    mr[d][a] = v;
    check_regs(d, "load");
  endtask

  // One instruction through IDLE->EXEC->WB->IDLE with cycle-exact checks.
  // ldv: same-edge load; hold: keep issue_valid high throughout; blk: request a load while busy.
  task automatic do_issue(input int d, input logic [7:0] inst, input logic ldv,
                          input logic [1:0] lda, input logic [7:0] ldd,
                          input logic hold, input logic blk);
    logic [7:0] ra, rb;
    @(negedge clk);
    total++;
    if (issue_ready[d] !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready_idle d=%0d got=%b exp=1", d, issue_ready[d]);
    end
    issue_valid[d] = 1'b1; issue_inst[d] = inst;
    ld_valid[d] = ldv; ld_addr[d] = lda; ld_data[d] = ldd;
    ra = mr[d][inst[3:2]];
    rb = mr[d][inst[1:0]];
    if (ldv) mr[d][lda] = ldd;
    @(negedge clk);
    if (!hold) issue_valid[d] = 1'b0;
    ld_valid[d] = blk;
    if (blk) begin ld_addr[d] = 2'd2; ld_data[d] = 8'hC3; end
    for (int k = 0; k < ew(d); k++) begin
      total++;
      if (alu_ra[d] !== ra || alu_rb[d] !== rb || alu_inst[d] !== inst) begin
        bad++;
        $display("FAIL exec_operands d=%0d k=%0d got=%h/%h/%h exp=%h/%h/%h",
                 d, k, alu_ra[d], alu_rb[d], alu_inst[d], ra, rb, inst);
      end
      total++;
      if (issue_ready[d] !== 1'b0 || ld_ready[d] !== 1'b0 || wb_done[d] !== 1'b0) begin
        bad++;
        $display("FAIL exec_ctrl d=%0d k=%0d got=%b%b%b exp=000",
                 d, k, issue_ready[d], ld_ready[d], wb_done[d]);
      end
      if (ldv && k == 0) begin
        rd_addr[d] = lda;
        #1;
        total++;
        if (rd_data[d] !== ldd) begin
          bad++;
          $display("FAIL same_edge_load d=%0d got=%h exp=%h", d, rd_data[d], ldd);
        end
      end
      @(negedge clk);
    end
    total++;
    if (wb_done[d] !== 1'b1 || issue_ready[d] !== 1'b0 || ld_ready[d] !== 1'b0 || alu_inst[d] !== inst) begin
      bad++;
      $display("FAIL wb_cycle d=%0d got=%b%b%b/%h exp=100/%h",
               d, wb_done[d], issue_ready[d], ld_ready[d], alu_inst[d], inst);
    end
    if (is_alu_op(inst[7:4])) begin
      mr[d][inst[3:2]] = alu_fn(ra, rb, inst);
      mflags[d]        = flag_fn(ra, rb, inst);
    end
    @(negedge clk);
    issue_valid[d] = 1'b0;
    ld_valid[d]    = 1'b0;
    total++;
    if (wb_done[d] !== 1'b0 || issue_ready[d] !== 1'b1 || ld_ready[d] !== 1'b1 ||
        alu_inst[d] !== 8'h00 || alu_ra[d] !== ra || alu_rb[d] !== rb) begin
      bad++;
      $display("FAIL post_wb d=%0d got=%b%b%b/%h/%h/%h exp=011/00/%h/%h",
               d, wb_done[d], issue_ready[d], ld_ready[d], alu_inst[d], alu_ra[d], alu_rb[d], ra, rb);
    end
    check_regs(d, "post_wb");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (issue_ready[d] !== 1'b1 || ld_ready[d] !== 1'b1 || wb_done[d] !== 1'b0 ||
          alu_ra[d] !== 8'h00 || alu_rb[d] !== 8'h00 || alu_inst[d] !== 8'h00) begin
        bad++;
        $display("FAIL reset_state d=%0d got=%b%b%b/%h/%h/%h exp=110/00/00/00",
                 d, issue_ready[d], ld_ready[d], wb_done[d], alu_ra[d], alu_rb[d], alu_inst[d]);
      end
      check_regs(d, "reset");
    end
  endtask

  task automatic test_add();
    do_load(0, 2'd0, 8'h05);
    do_load(0, 2'd1, 8'h03);
    do_issue(0, 8'hA1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_sub_inc();
    do_load(0, 2'd0, 8'h03);
    do_load(0, 2'd1, 8'h05);
    do_issue(0, 8'hB1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_load(0, 2'd3, 8'hFF);
    do_issue(0, 8'h8C, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_mul();
    do_load(0, 2'd0, 8'h0F);
    do_load(0, 2'd1, 8'h0F);
    do_issue(0, 8'h41, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_load(0, 2'd0, 8'h0F);
    do_load(0, 2'd1, 8'h02);
    do_issue(0, 8'h51, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_non_alu();
    do_load(0, 2'd0, 8'h77);
    do_load(0, 2'd1, 8'h12);
    do_issue(0, 8'h21, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
    do_load(1, 2'd0, 8'h77);
    do_issue(1, 8'h21, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_load_with_issue();
    do_load(1, 2'd0, 8'h05);
    do_load(1, 2'd1, 8'h03);
    do_issue(1, 8'hA1, 1'b1, 2'd0, 8'h10, 1'b0, 1'b0);
    do_issue(1, 8'h96, 1'b1, 2'd2, 8'h44, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] inst;
    int d;
    for (int n = 0; n < 30; n++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) do_load(d, 2'($urandom), 8'($urandom));
      inst = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: inst[7:4] = 4'h8;
          1: inst[7:4] = 4'h9;
          2: inst[7:4] = 4'hA;
          3: inst[7:4] = 4'hB;
          4: inst[7:4] = 4'h4;
          default: inst[7:4] = 4'h5;
        endcase
      end
      do_issue(d, inst, 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    do_issue(0, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_issue(0, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_issue(1, 8'hBA, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_issue(1, 8'hBA, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    do_load(1, 2'd0, 8'h05);
    do_load(1, 2'd1, 8'h03);
    @(negedge clk);
    issue_valid[1] = 1'b1; issue_inst[1] = 8'hA1;
    @(negedge clk);
    issue_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    #1;
    total++;
    if (issue_ready[1] !== 1'b1 || alu_inst[1] !== 8'h00 || wb_done[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_exec got=%b/%h/%b exp=1/00/0", issue_ready[1], alu_inst[1], wb_done[1]);
    end
    check_regs(1, "reset_mid_exec");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      total++;
      if (wb_done[1] !== 1'b0 || wb_done[0] !== 1'b0) begin
        bad++;
        $display("FAIL no_wb_after_reset k=%0d got=%b%b exp=00", k, wb_done[1], wb_done[0]);
      end
    end
    check_regs(1, "after_reset");
    check_regs(0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      issue_valid[d] = 1'b0; issue_inst[d] = 8'h00;
      ld_valid[d] = 1'b0; ld_addr[d] = 2'd0; ld_data[d] = 8'h00; rd_addr[d] = 2'd0;
    end
    test_reset();
    test_add();
    test_sub_inc();
    test_mul();
    test_non_alu();
    test_load_with_issue();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
